hazard_scoreboard_ctrl: RTL and testbench

Parametrised pipeline hazard controller for the 5-stage RV32I core; successor to the single-cycle forwarding/hazard unit. It selects forwarding sources for EX operands and ID branch-compare operands, and detects hazards. A small FSM stretches load-use stalls to a configurable latency and freezes the pipeline while data memory is not ready. It sits beside the pipeline registers and drives their stall/flush controls and the forwarding muxes.

---
 rtl/hazard_scoreboard_ctrl_pkg.sv | 35 +++
 rtl/hazard_scoreboard_ctrl_src_match.sv | 16 +
 rtl/hazard_scoreboard_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_hazard_scoreboard_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_ctrl_pkg.sv
// Shared types for the hazard controller: FSM states,
// forwarding/branch select encodings and the stall/flush bundle.
package hazard_scoreboard_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LDSTALL = 2'd1,
    DMWAIT  = 2'd2
  } haz_state_e;

  typedef enum logic [1:0] {
    FWD_NONE    = 2'b00,
    FWD_MEM_ALU = 2'b01,
    FWD_WB      = 2'b10,
    FWD_MEM_LD  = 2'b11
  } fwd_sel_e;

  typedef enum logic [1:0] {
    BR_RF      = 2'b00,
    BR_EX      = 2'b01,
    BR_MEM_ALU = 2'b10,
    BR_MEM_LD  = 2'b11
  } br_sel_e;

  typedef struct packed {
    logic stall_if;
    logic stall_id;
    logic stall_ex;
    logic stall_mem;
    logic flush_id;
    logic flush_ex;
    logic flush_wb;
  } haz_ctl_t;

endpackage

// File: rtl/hazard_scoreboard_ctrl_src_match.sv
// Source/producer comparator: hit when a used, non-x0 source
// register is written by the producer stage.
module hazard_src_match #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src_addr,
  input  logic              src_used,
  input  logic [REG_AW-1:0] prd_addr,
  input  logic              prd_wren,
  output logic              hit
);

  assign hit = (src_addr != '0) && src_used && prd_wren &&
               (src_addr == prd_addr);

endmodule

// File: rtl/hazard_scoreboard_ctrl.sv
// Pipeline hazard controller: forwarding selects, load-use and
// dmem stalls, branch flushes. HAZ_PERF_CNT_EN adds perf counters.
module hazard_scoreboard_ctrl
  import hazard_scoreboard_ctrl_pkg::*;
#(
  parameter int LOAD_USE_CYC = 1,
  parameter int REG_AW       = 5,
  parameter int CNT_W        = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [REG_AW-1:0] i_id_rs1_addr,
  input  logic [REG_AW-1:0] i_id_rs2_addr,
  input  logic              i_id_rs1_used,
  input  logic              i_id_rs2_used,
  input  logic [REG_AW-1:0] i_ex_rs1_addr,
  input  logic [REG_AW-1:0] i_ex_rs2_addr,
  input  logic [REG_AW-1:0] i_ex_rd_addr,
  input  logic              i_ex_rd_wren,
  input  logic              i_ex_is_load,
  input  logic              i_ex_br_taken,
  input  logic [REG_AW-1:0] i_mem_rd_addr,
  input  logic              i_mem_rd_wren,
  input  logic              i_mem_is_load,
  input  logic              i_mem_is_mem,
  input  logic              i_dmem_ready,
  input  logic [REG_AW-1:0] i_wb_rd_addr,
  input  logic              i_wb_rd_wren,
  output logic              o_stall_if,
  output logic              o_stall_id,
  output logic              o_stall_ex,
  output logic              o_stall_mem,
  output logic              o_flush_id,
  output logic              o_flush_ex,
  output logic              o_flush_wb,
  output logic [1:0]        o_fwd_rs1_sel,
  output logic [1:0]        o_fwd_rs2_sel,
  output logic [1:0]        o_br_rs1_sel,
  output logic [1:0]        o_br_rs2_sel,
  output logic              o_id_rs1_wb_byp,
  output logic              o_id_rs2_wb_byp
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  o_cnt_ld_stall,
  output logic [CNT_W-1:0]  o_cnt_dmem_stall,
  output logic [CNT_W-1:0]  o_cnt_flush
`endif
);

  // Load data only sits in MEM for a consumer when there is one bubble
  localparam bit         LD_FWD   = (LOAD_USE_CYC == 1);
  localparam logic [1:0] CNT_INIT = 2'(LOAD_USE_CYC - 1);

  logic [REG_AW-1:0] ex_rs [2];
  logic [REG_AW-1:0] id_rs [2];
  logic [1:0] id_used;
  logic [1:0] ex_mem_hit, ex_wb_hit;
  logic [1:0] id_ex_hit, id_mem_hit, id_wb_hit;

  assign ex_rs[0] = i_ex_rs1_addr;
  assign ex_rs[1] = i_ex_rs2_addr;
  assign id_rs[0] = i_id_rs1_addr;
  assign id_rs[1] = i_id_rs2_addr;
  assign id_used  = {i_id_rs2_used, i_id_rs1_used};

  for (genvar g = 0; g < 2; g++) begin : g_src
    hazard_src_match #(.REG_AW(REG_AW)) u_ex_mem (
      .src_addr(ex_rs[g]), .src_used(1'b1),
      .prd_addr(i_mem_rd_addr), .prd_wren(i_mem_rd_wren),
      .hit(ex_mem_hit[g]));
    hazard_src_match #(.REG_AW(REG_AW)) u_ex_wb (
      .src_addr(ex_rs[g]), .src_used(1'b1),
      .prd_addr(i_wb_rd_addr), .prd_wren(i_wb_rd_wren),
      .hit(ex_wb_hit[g]));
    hazard_src_match #(.REG_AW(REG_AW)) u_id_ex (
      .src_addr(id_rs[g]), .src_used(id_used[g]),
      .prd_addr(i_ex_rd_addr), .prd_wren(i_ex_rd_wren),
      .hit(id_ex_hit[g]));
    hazard_src_match #(.REG_AW(REG_AW)) u_id_mem (
      .src_addr(id_rs[g]), .src_used(id_used[g]),
      .prd_addr(i_mem_rd_addr), .prd_wren(i_mem_rd_wren),
      .hit(id_mem_hit[g]));
    hazard_src_match #(.REG_AW(REG_AW)) u_id_wb (
      .src_addr(id_rs[g]), .src_used(id_used[g]),
      .prd_addr(i_wb_rd_addr), .prd_wren(i_wb_rd_wren),
      .hit(id_wb_hit[g]));
  end

  fwd_sel_e fwd_sel [2];
  br_sel_e  br_sel  [2];

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      fwd_sel[k] = FWD_NONE;
      if (ex_mem_hit[k] && !i_mem_is_load)
        fwd_sel[k] = FWD_MEM_ALU;
      else if (ex_mem_hit[k] && LD_FWD)
        fwd_sel[k] = FWD_MEM_LD;
      else if (ex_wb_hit[k])
        fwd_sel[k] = FWD_WB;

      br_sel[k] = BR_RF;
      if (id_ex_hit[k] && !i_ex_is_load)
        br_sel[k] = BR_EX;
      else if (id_mem_hit[k] && !i_mem_is_load)
        br_sel[k] = BR_MEM_ALU;
      else if (id_mem_hit[k] && LD_FWD)
        br_sel[k] = BR_MEM_LD;
    end
  end

  assign o_fwd_rs1_sel   = fwd_sel[0];
  assign o_fwd_rs2_sel   = fwd_sel[1];
  assign o_br_rs1_sel    = br_sel[0];
  assign o_br_rs2_sel    = br_sel[1];
  assign o_id_rs1_wb_byp = id_wb_hit[0];
  assign o_id_rs2_wb_byp = id_wb_hit[1];

  haz_state_e state_q, state_d, ret_q, ret_d, eff;
  logic [1:0] cnt_q, cnt_d;
  logic       ld_use, dm_wait, ld_stall, br_flush;
  haz_ctl_t   ctl;

  assign ld_use  = i_ex_is_load && (|id_ex_hit);
  assign dm_wait = i_mem_is_mem && !i_dmem_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      ret_q   <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
    end
  end

  // DMWAIT is transparent once ready: the saved state acts that cycle
  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    cnt_d    = cnt_q;
    ld_stall = 1'b0;
    br_flush = 1'b0;
    ctl      = '0;
    eff      = (state_q == DMWAIT) ? ret_q : state_q;
    if (dm_wait) begin
      state_d       = DMWAIT;
      ret_d         = eff;
      ctl.stall_if  = 1'b1;
      ctl.stall_id  = 1'b1;
      ctl.stall_ex  = 1'b1;
      ctl.stall_mem = 1'b1;
      ctl.flush_wb  = 1'b1;
    end else if (i_ex_br_taken) begin
      state_d  = IDLE;
      cnt_d    = '0;
      br_flush = 1'b1;
    end else begin
      unique case (eff)
        LDSTALL: begin
          ld_stall = 1'b1;
          cnt_d    = cnt_q - 2'd1;
          state_d  = (cnt_q == 2'd1) ? IDLE : LDSTALL;
        end
        default: begin
          state_d = IDLE;
          if (ld_use) begin
            ld_stall = 1'b1;
            cnt_d    = CNT_INIT;
            state_d  = (CNT_INIT == 2'd0) ? IDLE : LDSTALL;
          end
        end
      endcase
    end
    if (ld_stall) begin
      ctl.stall_if = 1'b1;
      ctl.stall_id = 1'b1;
    end
    ctl.flush_id = br_flush;
    ctl.flush_ex = br_flush | ld_stall;
  end

  assign o_stall_if  = ctl.stall_if;
  assign o_stall_id  = ctl.stall_id;
  assign o_stall_ex  = ctl.stall_ex;
  assign o_stall_mem = ctl.stall_mem;
  assign o_flush_id  = ctl.flush_id;
  assign o_flush_ex  = ctl.flush_ex;
  assign o_flush_wb  = ctl.flush_wb;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_ld_q, cnt_dm_q, cnt_fl_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_ld_q <= '0;
      cnt_dm_q <= '0;
      cnt_fl_q <= '0;
    end else begin
      if (ld_stall && !(&cnt_ld_q))
        cnt_ld_q <= cnt_ld_q + CNT_W'(1);
      if (dm_wait && !(&cnt_dm_q))
        cnt_dm_q <= cnt_dm_q + CNT_W'(1);
      if (br_flush && !(&cnt_fl_q))
        cnt_fl_q <= cnt_fl_q + CNT_W'(1);
    end
  end

  assign o_cnt_ld_stall   = cnt_ld_q;
  assign o_cnt_dmem_stall = cnt_dm_q;
  assign o_cnt_flush      = cnt_fl_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// Bench for hazard_scoreboard_ctrl: LOAD_USE_CYC=1 and =3 side by
// side, checked each cycle against a rule-level model.
module tb_hazard_scoreboard_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic id_u1, id_u2, ex_wren, ex_ld, br;
  logic mem_wren, mem_ld, mem_mem, rdy, wb_wren;

  logic [1:0] s_if, s_id, s_ex, s_mem, f_id, f_ex, f_wb;
  logic [1:0] byp1, byp2;
  logic [1:0] fwd1 [2];
  logic [1:0] fwd2 [2];
  logic [1:0] br1 [2];
  logic [1:0] br2 [2];
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] c_ld [2];
  logic [31:0] c_dm [2];
  logic [31:0] c_fl [2];
`endif

  int total = 0;
  int bad = 0;
  int rem [2];
  int m_ld [2];
  int m_dm [2];
  int m_fl [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    hazard_scoreboard_ctrl #(.LOAD_USE_CYC(g == 0 ? 1 : 3)) u_dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_id_rs1_addr(id_rs1), .i_id_rs2_addr(id_rs2),
      .i_id_rs1_used(id_u1), .i_id_rs2_used(id_u2),
      .i_ex_rs1_addr(ex_rs1), .i_ex_rs2_addr(ex_rs2),
      .i_ex_rd_addr(ex_rd), .i_ex_rd_wren(ex_wren),
      .i_ex_is_load(ex_ld), .i_ex_br_taken(br),
      .i_mem_rd_addr(mem_rd), .i_mem_rd_wren(mem_wren),
      .i_mem_is_load(mem_ld), .i_mem_is_mem(mem_mem),
      .i_dmem_ready(rdy),
      .i_wb_rd_addr(wb_rd), .i_wb_rd_wren(wb_wren),
      .o_stall_if(s_if[g]), .o_stall_id(s_id[g]),
      .o_stall_ex(s_ex[g]), .o_stall_mem(s_mem[g]),
      .o_flush_id(f_id[g]), .o_flush_ex(f_ex[g]),
      .o_flush_wb(f_wb[g]),
      .o_fwd_rs1_sel(fwd1[g]), .o_fwd_rs2_sel(fwd2[g]),
      .o_br_rs1_sel(br1[g]), .o_br_rs2_sel(br2[g]),
      .o_id_rs1_wb_byp(byp1[g]), .o_id_rs2_wb_byp(byp2[g])
`ifdef HAZ_PERF_CNT_EN
      ,
      .o_cnt_ld_stall(c_ld[g]), .o_cnt_dmem_stall(c_dm[g]),
      .o_cnt_flush(c_fl[g])
`endif
    );
  end

  function automatic bit hit(logic [4:0] s, logic u,
                             logic [4:0] d, logic w);
    return (s != 5'd0) && u && w && (s == d);
  endfunction

  function automatic logic [1:0] m_fwd(logic [4:0] s, int k);
    if (hit(s, 1'b1, mem_rd, mem_wren)) begin
      if (!mem_ld) return 2'b01;
      if (k == 0) return 2'b11;
    end
    if (hit(s, 1'b1, wb_rd, wb_wren)) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [1:0] m_br(logic [4:0] s, logic u, int k);
    if (hit(s, u, ex_rd, ex_wren) && !ex_ld) return 2'b01;
    if (hit(s, u, mem_rd, mem_wren)) begin
      if (!mem_ld) return 2'b10;
      if (k == 0) return 2'b11;
    end
    return 2'b00;
  endfunction

  function automatic bit m_lu();
    return ex_ld && (hit(id_rs1, id_u1, ex_rd, ex_wren) ||
                     hit(id_rs2, id_u2, ex_rd, ex_wren));
  endfunction

  function automatic logic [16:0] m_exp(int k);
    logic [6:0] c;
    if (mem_mem && !rdy)          c = 7'b1111_001;
    else if (br)                  c = 7'b0000_110;
    else if (rem[k] > 0 || m_lu()) c = 7'b1100_010;
    else                          c = 7'b0000_000;
    return {c, m_fwd(ex_rs1, k), m_fwd(ex_rs2, k),
            m_br(id_rs1, id_u1, k), m_br(id_rs2, id_u2, k),
            hit(id_rs1, id_u1, wb_rd, wb_wren),
            hit(id_rs2, id_u2, wb_rd, wb_wren)};
  endfunction

  function automatic logic [16:0] dut_v(int k);
    return {s_if[k], s_id[k], s_ex[k], s_mem[k],
            f_id[k], f_ex[k], f_wb[k],
            fwd1[k], fwd2[k], br1[k], br2[k], byp1[k], byp2[k]};
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  task automatic settle();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk(k == 0 ? "model_l1" : "model_l3",
          32'(dut_v(k)), 32'(m_exp(k)));
`ifdef HAZ_PERF_CNT_EN
      chk("cnt_ld", c_ld[k], 32'(m_ld[k]));
      chk("cnt_dm", c_dm[k], 32'(m_dm[k]));
      chk("cnt_fl", c_fl[k], 32'(m_fl[k]));
`endif
    end
  endtask

  task automatic adv();
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        rem[k] = 0; m_ld[k] = 0; m_dm[k] = 0; m_fl[k] = 0;
      end else if (mem_mem && !rdy) begin
        m_dm[k]++;
      end else if (br) begin
        rem[k] = 0; m_fl[k]++;
      end else if (rem[k] > 0) begin
        rem[k]--; m_ld[k]++;
      end else if (m_lu()) begin
        rem[k] = (k == 0 ? 1 : 3) - 1; m_ld[k]++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    settle();
    adv();
  endtask

  task automatic clr();
    id_rs1 = '0; id_rs2 = '0; ex_rs1 = '0; ex_rs2 = '0;
    ex_rd = '0; mem_rd = '0; wb_rd = '0;
    id_u1 = 0; id_u2 = 0; ex_wren = 0; ex_ld = 0; br = 0;
    mem_wren = 0; mem_ld = 0; mem_mem = 0; rdy = 1; wb_wren = 0;
  endtask

  task automatic load_x(logic [4:0] r);
    ex_ld = 1; ex_wren = 1; ex_rd = r; id_rs1 = r; id_u1 = 1;
  endtask

  initial begin
    clr();
    settle();
    chk("reset_l1", 32'(dut_v(0)), 32'd0);
    chk("reset_l3", 32'(dut_v(1)), 32'd0);
    adv();
    rst_n = 1;

    wb_rd = 5; wb_wren = 1; ex_rs1 = 5; mem_rd = 5; mem_wren = 1;
    settle(); chk("fwd_mem_alu", fwd1[0], 2'b01); adv();
    mem_wren = 0;
    settle(); chk("fwd_wb", fwd1[0], 2'b10); adv();
    ex_rs1 = 0;
    settle(); chk("fwd_x0", fwd1[0], 2'b00); adv();

    clr(); ex_rs2 = 9; mem_rd = 9; mem_wren = 1; mem_ld = 1;
    mem_mem = 1; wb_rd = 9; wb_wren = 1;
    settle();
    chk("fwd_ld_l1", fwd2[0], 2'b11);
    chk("fwd_ld_l3", fwd2[1], 2'b10);
    adv();

    clr(); id_rs1 = 4; id_u1 = 1; ex_rd = 4; ex_wren = 1;
    id_rs2 = 6; id_u2 = 1; wb_rd = 6; wb_wren = 1;
    mem_rd = 6; mem_wren = 1;
    settle();
    chk("br_ex", br1[0], 2'b01);
    chk("br_mem_alu", br2[0], 2'b10);
    chk("wb_byp", byp2[0], 1);
    adv();

    clr(); ex_ld = 1; ex_wren = 1; ex_rd = 7; id_rs2 = 7; id_u2 = 1;
    settle();
    chk("lu_det_l1", {s_if[0], s_id[0], f_ex[0]}, 3'b111);
    chk("lu_det_l3", {s_if[1], s_id[1], f_ex[1]}, 3'b111);
    adv();
    clr(); id_rs2 = 7; id_u2 = 1; ex_rs2 = 7;
    mem_rd = 7; mem_wren = 1; mem_ld = 1; mem_mem = 1;
    settle();
    chk("lu_fwd_l1", fwd2[0], 2'b11);
    chk("lu_done_l1", s_id[0], 0);
    chk("lu_2nd_l3", s_id[1], 1);
    adv();
    clr(); id_rs2 = 7; id_u2 = 1;
    settle(); chk("lu_3rd_l3", s_id[1], 1); adv();
    settle(); chk("lu_end_l3", s_id[1], 0); adv();
    ex_ld = 1; ex_wren = 1; ex_rd = 7; id_u2 = 0;
    settle(); chk("lu_unused", s_id[1], 0); adv();

    clr(); mem_mem = 1; mem_ld = 1; rdy = 0;
    repeat (4) begin
      settle();
      chk("dm_wait", {s_if[0], s_id[0], s_ex[0], s_mem[0], f_wb[0]},
          5'b11111);
      adv();
    end
    rdy = 1;
    settle();
    chk("dm_rel", {s_if[0], s_id[0], s_ex[0], s_mem[0], f_wb[0]}, 0);
    adv();

    clr(); load_x(7); cyc();
    clr(); id_rs1 = 7; id_u1 = 1; mem_mem = 1; rdy = 0;
    cyc(); cyc();
    rdy = 1;
    settle();
    chk("ld_resume_l3", {s_id[1], s_mem[1]}, 2'b10);
    chk("ld_resume_l1", s_id[0], 0);
    adv();
    clr();
    settle(); chk("ld_last_l3", s_id[1], 1); adv();
    settle(); chk("ld_over_l3", s_id[1], 0); adv();

    clr(); mem_mem = 1; rdy = 0; br = 1;
    repeat (2) begin
      settle(); chk("br_defer", {f_id[0], f_ex[0]}, 2'b00); adv();
    end
    rdy = 1;
    settle(); chk("br_flush", {f_id[0], f_ex[0]}, 2'b11); adv();
    clr();
    settle(); chk("br_once", {f_id[0], f_ex[0]}, 2'b00); adv();

    load_x(3); cyc();
    clr(); br = 1;
    settle(); chk("br_in_ld_l3", {s_id[1], f_id[1]}, 2'b01); adv();
    clr();
    settle(); chk("br_exit_l3", s_id[1], 0); adv();

    load_x(3); cyc();
    clr(); settle();
    rst_n = 0;
    #1;
    chk("rst_mid_l3", 32'(dut_v(1)), 32'd0);
`ifdef HAZ_PERF_CNT_EN
    chk("rst_cnt", c_ld[1] | c_dm[1] | c_fl[1], 32'd0);
`endif
    adv();
    rst_n = 1;
    settle(); chk("rst_idle_l3", s_id[1], 0); adv();

    repeat (3) begin
      load_x(3); cyc();
      clr(); cyc(); cyc(); cyc();
    end
    repeat (2) begin
      br = 1; cyc();
      clr(); cyc();
    end
`ifdef HAZ_PERF_CNT_EN
    settle();
    chk("perf_ld", c_ld[0], 32'd3);
    chk("perf_dm", c_dm[0], 32'd0);
    chk("perf_fl", c_fl[0], 32'd2);
    chk("perf_ld_l3", c_ld[1], 32'd9);
    adv();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
